// File: rtl/alu_arbiter_if.sv
// Requester handshakes (two ports) plus the ALU-side bus for alu_arbiter.
// slave is the arbiter's view; master is the view of the requesters and the ALU together.
interface alu_arbiter_if #(
  parameter int WIDTH = 32
);
  logic             req0Valid;
  logic             req0Ready;
  logic [3:0]       req0Op;
  logic [WIDTH-1:0] req0A;
  logic [WIDTH-1:0] req0B;
  logic             rsp0Valid;
  logic             rsp0Ready;
  logic [WIDTH-1:0] rsp0Result;
  logic             rsp0Zero;
  logic             rsp0Err;

  logic             req1Valid;
  logic             req1Ready;
  logic [3:0]       req1Op;
  logic [WIDTH-1:0] req1A;
  logic [WIDTH-1:0] req1B;
  logic             rsp1Valid;
  logic             rsp1Ready;
  logic [WIDTH-1:0] rsp1Result;
  logic             rsp1Zero;
  logic             rsp1Err;

  logic [WIDTH-1:0] aluInput1;
  logic [WIDTH-1:0] aluInput2;
  logic [3:0]       aluControl;
  logic [WIDTH-1:0] aluResult;
  logic             aluZero;

  modport slave (
    input  req0Valid, req0Op, req0A, req0B, rsp0Ready,
    input  req1Valid, req1Op, req1A, req1B, rsp1Ready,
    input  aluResult, aluZero,
    output req0Ready, rsp0Valid, rsp0Result, rsp0Zero, rsp0Err,
    output req1Ready, rsp1Valid, rsp1Result, rsp1Zero, rsp1Err,
    output aluInput1, aluInput2, aluControl
  );

  modport master (
    output req0Valid, req0Op, req0A, req0B, rsp0Ready,
    output req1Valid, req1Op, req1A, req1B, rsp1Ready,
    output aluResult, aluZero,
    input  req0Ready, rsp0Valid, rsp0Result, rsp0Zero, rsp0Err,
    input  req1Ready, rsp1Valid, rsp1Result, rsp1Zero, rsp1Err,
    input  aluInput1, aluInput2, aluControl
  );
endinterface

// File: rtl/alu_arbiter.sv
// Round-robin sharing of one multi-cycle ALU between two requesters; one transaction in flight,
// IDLE accept -> EXEC for ALU_LATENCY cycles -> RESP until the owner consumes the response.
module alu_arbiter #(
  parameter int WIDTH       = 32,
  parameter int ALU_LATENCY = 1
) (
  input  logic         clock,
  input  logic         resetN,
  alu_arbiter_if.slave bus
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    EXEC = 2'd1,
    RESP = 2'd2
  } stateT;

  stateT            state;
  stateT            stateNext;

  logic             armed;
  logic             prioPtr;
  logic             owner;
  logic [3:0]       latCnt;
  logic [3:0]       opReg;
  logic [WIDTH-1:0] aReg;
  logic [WIDTH-1:0] bReg;
  logic [WIDTH-1:0] resultReg;
  logic             zeroReg;
  logic             errReg;

  logic             grant0;
  logic             grant1;
  logic             accept;
  logic             winLegal;
  logic             lastExec;
  logic             ownerReady;
  logic [3:0]       winOp;
  logic [WIDTH-1:0] winA;
  logic [WIDTH-1:0] winB;

  function automatic logic isLegal(input logic [3:0] op);
    case (op)
      4'b0010, 4'b0110, 4'b0001, 4'b0000, 4'b0100: isLegal = 1'b1;
      default:                                      isLegal = 1'b0;
    endcase
  endfunction

  // armed keeps both readies low until the first edge after reset release.
  always_comb begin
    // NOTE: every signal gets a default before the branches, so no path leaves it unassigned and no latch is inferred.
    grant0 = 1'b0;
    grant1 = 1'b0;
    if (state == IDLE && armed) begin
      if (bus.req0Valid && (!bus.req1Valid || !prioPtr)) begin
        grant0 = 1'b1;
      end else if (bus.req1Valid) begin
        grant1 = 1'b1;
      end
    end
  end

  assign accept     = grant0 | grant1;
  assign winOp      = grant1 ? bus.req1Op : bus.req0Op;
  assign winA       = grant1 ? bus.req1A  : bus.req0A;
  assign winB       = grant1 ? bus.req1B  : bus.req0B;
  assign winLegal   = isLegal(winOp);
  assign lastExec   = (latCnt == 4'(ALU_LATENCY - 1));
  assign ownerReady = owner ? bus.rsp1Ready : bus.rsp0Ready;

  always_ff @(posedge clock or negedge resetN) begin
    if (!resetN) begin
      state <= IDLE;
    end else begin
      state <= stateNext;
    end
  end

  always_comb begin
    stateNext = state;
    case (state)
      IDLE: begin
        if (accept) begin
          stateNext = winLegal ? EXEC : RESP;
        end
      end
      EXEC: begin
        if (lastExec) begin
          stateNext = RESP;
        end
      end
      RESP: begin
        if (ownerReady) begin
          stateNext = IDLE;
        end
      end
      default: stateNext = IDLE;
    endcase
  end

  // Illegal opcodes never reach opReg, so the ALU keeps seeing its last legal command.
  always_ff @(posedge clock or negedge resetN) begin
    // NOTE: datapath registers are reset too, because every output must read 0 while reset is held.
    if (!resetN) begin
      armed     <= 1'b0;
      prioPtr   <= 1'b0;
      owner     <= 1'b0;
      latCnt    <= '0;
      opReg     <= '0;
      aReg      <= '0;
      bReg      <= '0;
      resultReg <= '0;
      zeroReg   <= 1'b0;
      errReg    <= 1'b0;
    end else begin
      // NOTE: non-blocking assignments so every register samples pre-edge values regardless of statement order.
      armed <= 1'b1;
      if (accept) begin
        owner   <= grant1;
        prioPtr <= ~grant1;
        if (winLegal) begin
          opReg  <= winOp;
          aReg   <= winA;
          bReg   <= winB;
          errReg <= 1'b0;
        end else begin
          resultReg <= '0;
          zeroReg   <= 1'b0;
          errReg    <= 1'b1;
        end
      end
      if (state == EXEC) begin
        if (lastExec) begin
          latCnt    <= '0;
          resultReg <= bus.aluResult;
          zeroReg   <= bus.aluZero;
        end else begin
          latCnt <= latCnt + 4'd1;
        end
      end
    end
  end

  assign bus.req0Ready  = grant0;
  assign bus.req1Ready  = grant1;
  assign bus.rsp0Valid  = (state == RESP) && !owner;
  assign bus.rsp1Valid  = (state == RESP) &&  owner;
  assign bus.rsp0Result = resultReg;
  assign bus.rsp1Result = resultReg;
  assign bus.rsp0Zero   = zeroReg;
  assign bus.rsp1Zero   = zeroReg;
  assign bus.rsp0Err    = errReg;
  assign bus.rsp1Err    = errReg;
  assign bus.aluInput1  = aReg;
  assign bus.aluInput2  = bReg;
  assign bus.aluControl = opReg;

endmodule

// File: tb/tb_alu_arbiter.sv
// Bench for alu_arbiter: directed scenarios plus randomized traffic on both ports, checked
// by a negedge monitor against a queue-based reference of results, grant order and latency.
module tb_alu_arbiter;

  localparam int WIDTH = 32;
  localparam int LAT   = 1;

  typedef struct packed {
    logic [WIDTH-1:0] result;
    logic             zero;
    logic             err;
  } rspT;

  logic clock  = 1'b0;
  logic resetN = 1'b0;
  always #5 clock = ~clock;

  alu_arbiter_if #(.WIDTH(WIDTH)) bus ();

  alu_arbiter #(.WIDTH(WIDTH), .ALU_LATENCY(LAT)) dut (
    .clock  (clock),
    .resetN (resetN),
    .bus    (bus)
  );

  // Behavioural ALU: combinational, so the sample at the end of the single EXEC cycle is valid.
  logic [WIDTH-1:0] aluR;
  always_comb begin
    aluR = 32'hDEAD_BEEF;
    case (bus.aluControl)
      4'b0010: aluR = bus.aluInput1 + bus.aluInput2;
      4'b0110: aluR = bus.aluInput1 + ~bus.aluInput2 + 32'd1;
      4'b0001: aluR = bus.aluInput1 | bus.aluInput2;
      4'b0000: aluR = bus.aluInput1 & bus.aluInput2;
      4'b0100: aluR = (bus.aluInput2 >= 32'(WIDTH)) ? '0 : (bus.aluInput1 << bus.aluInput2[4:0]);
      default: ;
    endcase
  end
  assign bus.aluResult = aluR;
  assign bus.aluZero   = (aluR == '0);

  int checks = 0;
  int errors = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic rspT refCalc(input logic [3:0] op, input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b);
    rspT r;
    r.err = 1'b0;
    case (op)
      4'b0010: r.result = a + b;
      4'b0110: r.result = a - b;
      4'b0001: r.result = a | b;
      4'b0000: r.result = a & b;
      4'b0100: r.result = a << b;
      default: begin
        r.result = '0;
        r.err    = 1'b1;
      end
    endcase
    r.zero = !r.err && (r.result == '0);
    return r;
  endfunction

  // Scoreboard state, owned by the monitor.
  rspT              exp0[$];
  rspT              exp1[$];
  int               grantLog[$];
  int               cyc        = 0;
  int               accCyc     = 0;
  int               expDelay   = 0;
  bit               busy       = 1'b0;
  bit               lastServed = 1'b1;
  bit               rspSeen    = 1'b0;
  rspT              held;
  logic [3:0]       curOp;
  logic [3:0]       ctlBefore;
  logic [WIDTH-1:0] curA;
  logic [WIDTH-1:0] curB;

  always @(negedge clock) begin
    rspT cur;
    rspT e;
    int  p;
    cyc++;
    if (!resetN) begin
      exp0.delete();
      exp1.delete();
      grantLog.delete();
      busy       = 1'b0;
      lastServed = 1'b1;
      rspSeen    = 1'b0;
    end else begin
      if (bus.req0Ready || bus.req1Ready) begin
        check("readyWhileBusy", 64'(busy), 64'd0);
        check("readyOneHot", 64'(bus.req0Ready & bus.req1Ready), 64'd0);
        check("readyNeedsValid", 64'((bus.req0Ready & bus.req0Valid) | (bus.req1Ready & bus.req1Valid)), 64'd1);
        if (bus.req0Valid && bus.req1Valid) begin
          check("rrWinner", 64'(bus.req1Ready), 64'(!lastServed));
        end
        p = bus.req1Ready ? 1 : 0;
        curOp = (p == 1) ? bus.req1Op : bus.req0Op;
        curA  = (p == 1) ? bus.req1A  : bus.req0A;
        curB  = (p == 1) ? bus.req1B  : bus.req0B;
        e = refCalc(curOp, curA, curB);
        if (p == 1) exp1.push_back(e);
        else        exp0.push_back(e);
        grantLog.push_back(p);
        lastServed = (p == 1);
        busy       = 1'b1;
        rspSeen    = 1'b0;
        accCyc     = cyc;
        expDelay   = e.err ? 1 : LAT + 1;
        ctlBefore  = bus.aluControl;
      end
      if (bus.rsp0Valid || bus.rsp1Valid) begin
        check("rspOneHot", 64'(bus.rsp0Valid & bus.rsp1Valid), 64'd0);
        check("rspOwner", 64'(bus.rsp1Valid), 64'(lastServed));
        check("rspExpected", 64'(busy), 64'd1);
        cur = bus.rsp1Valid ? {bus.rsp1Result, bus.rsp1Zero, bus.rsp1Err}
                            : {bus.rsp0Result, bus.rsp0Zero, bus.rsp0Err};
        if (!rspSeen) begin
          rspSeen = 1'b1;
          held    = cur;
          check("rspLatency", 64'(cyc - accCyc), 64'(expDelay));
          if (cur.err) begin
            check("aluCtlKept", 64'(bus.aluControl), 64'(ctlBefore));
          end else begin
            check("aluCtl", 64'(bus.aluControl), 64'(curOp));
            check("aluIn1", 64'(bus.aluInput1), 64'(curA));
            check("aluIn2", 64'(bus.aluInput2), 64'(curB));
          end
        end else begin
          check("rspStable", 64'(cur), 64'(held));
        end
        if (bus.rsp1Valid ? bus.rsp1Ready : bus.rsp0Ready) begin
          if (bus.rsp1Valid ? (exp1.size() == 0) : (exp0.size() == 0)) begin
            check("rspNoExpect", 64'd1, 64'd0);
          end else begin
            e = bus.rsp1Valid ? exp1.pop_front() : exp0.pop_front();
            check(bus.rsp1Valid ? "rsp1Data" : "rsp0Data", 64'(cur), 64'(e));
          end
          busy    = 1'b0;
          rspSeen = 1'b0;
        end
      end
    end
  end

  task automatic driveReq(input int p, input logic [3:0] op, input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b);
    if (p == 0) begin
      bus.req0Valid = 1'b1; bus.req0Op = op; bus.req0A = a; bus.req0B = b;
    end else begin
      bus.req1Valid = 1'b1; bus.req1Op = op; bus.req1A = a; bus.req1B = b;
    end
  endtask

  task automatic dropReq(input int p);
    if (p == 0) bus.req0Valid = 1'b0;
    else        bus.req1Valid = 1'b0;
  endtask

  task automatic waitAccept(input int p);
    int n   = 0;
    bit got = 1'b0;
    while (!got && n < 400) begin
      @(negedge clock);
      got = (p == 0) ? (bus.req0Ready === 1'b1) : (bus.req1Ready === 1'b1);
      n++;
    end
    @(posedge clock);
    #1;
    dropReq(p);
    if (!got) check($sformatf("acceptTimeout%0d", p), 64'd0, 64'd1);
  endtask

  task automatic sendReq(input int p, input logic [3:0] op, input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b);
    driveReq(p, op, a, b);
    waitAccept(p);
  endtask

  task automatic waitIdle();
    int n = 0;
    while ((busy || exp0.size() != 0 || exp1.size() != 0) && n < 300) begin
      @(negedge clock);
      n++;
    end
    check("drainInTime", 64'(n < 300), 64'd1);
    @(posedge clock);
    #1;
  endtask

  task automatic doReset();
    bus.req0Valid = 1'b0;
    bus.req1Valid = 1'b0;
    resetN = 1'b0;
    repeat (2) @(negedge clock);
    resetN = 1'b1;
    @(posedge clock);
    #1;
  endtask

  task automatic randStim(output logic [3:0] op, output logic [WIDTH-1:0] a, output logic [WIDTH-1:0] b);
    case ($urandom_range(0, 5))
      0:       op = 4'b0010;
      1:       op = 4'b0110;
      2:       op = 4'b0001;
      3:       op = 4'b0000;
      4:       op = 4'b0100;
      default: op = 4'($urandom_range(0, 15));
    endcase
    a = $urandom;
    b = ($urandom_range(0, 3) == 0) ? a : $urandom;
    if (op == 4'b0100) b = $urandom_range(0, 40);
  endtask

  task automatic randPort(input int p, input int nOps);
    for (int i = 0; i < nOps; i++) begin
      logic [3:0]       op;
      logic [WIDTH-1:0] a;
      logic [WIDTH-1:0] b;
      int               gap;
      randStim(op, a, b);
      gap = $urandom_range(0, 2);
      repeat (gap) begin
        @(posedge clock);
        #1;
      end
      sendReq(p, op, a, b);
    end
  endtask

  bit randDone = 1'b0;

  initial begin
    #500000;
    $display("FAIL watchdog expired at %0t", $time);
    $fatal(1, "watchdog");
  end

  initial begin
    int n;
    bus.req0Valid = 1'b0; bus.req0Op = '0; bus.req0A = '0; bus.req0B = '0; bus.rsp0Ready = 1'b0;
    bus.req1Valid = 1'b0; bus.req1Op = '0; bus.req1A = '0; bus.req1B = '0; bus.rsp1Ready = 1'b0;

    // Reset state, with a request already pending on port 0.
    bus.req0Valid = 1'b1;
    repeat (2) @(negedge clock);
    check("rstHandshake", 64'({bus.req0Ready, bus.req1Ready, bus.rsp0Valid, bus.rsp1Valid}), 64'd0);
    check("rstRsp", 64'({bus.rsp0Result, bus.rsp0Zero, bus.rsp0Err, bus.rsp1Zero, bus.rsp1Err}), 64'd0);
    check("rstAlu", 64'({bus.aluControl, bus.aluInput1}), 64'd0);
    check("rstAluIn2", 64'(bus.aluInput2), 64'd0);
    bus.req0Valid = 1'b0;
    doReset();

    // Port 0 add 5+7: ready in cycle 0, response in cycle 2.
    bus.rsp0Ready = 1'b1;
    bus.rsp1Ready = 1'b1;
    driveReq(0, 4'b0010, 32'd5, 32'd7);
    @(negedge clock);
    check("t1Ready", 64'(bus.req0Ready), 64'd1);
    @(posedge clock);
    #1;
    dropReq(0);
    @(negedge clock);
    check("t1NotYet", 64'(bus.rsp0Valid), 64'd0);
    @(negedge clock);
    check("t1Valid", 64'(bus.rsp0Valid), 64'd1);
    check("t1Result", 64'({bus.rsp0Result, bus.rsp0Zero, bus.rsp0Err}), 64'({32'd12, 1'b0, 1'b0}));
    waitIdle();

    // Both ports after reset: port 0 first.
    doReset();
    fork
      sendReq(0, 4'b0110, 32'd9, 32'd9);
      sendReq(1, 4'b0001, 32'h0000_00F0, 32'h0000_000F);
    join
    waitIdle();
    check("t2Grants", 64'(grantLog.size()), 64'd2);
    if (grantLog.size() == 2) begin
      check("t2First", 64'(grantLog[0]), 64'd0);
      check("t2Second", 64'(grantLog[1]), 64'd1);
    end

    // Both ports held valid back to back: strict alternation.
    doReset();
    fork
      for (int i = 0; i < 2; i++) sendReq(0, 4'b0000, 32'hFF00_FF00, 32'h0FF0_0FF0);
      for (int i = 0; i < 2; i++) sendReq(1, 4'b0100, 32'h0000_0003, 32'd4);
    join
    waitIdle();
    check("t3Grants", 64'(grantLog.size()), 64'd4);
    for (int i = 0; i < grantLog.size(); i++) begin
      check($sformatf("t3Grant%0d", i), 64'(grantLog[i]), 64'(i % 2));
    end

    // Illegal opcode on port 1.
    begin
      logic [3:0] ctl;
      ctl = bus.aluControl;
      sendReq(1, 4'b1111, 32'h1234, 32'h5678);
      waitIdle();
      check("t4AluCtl", 64'(bus.aluControl), 64'(ctl));
    end

    // Backpressure on port 0 while port 1 waits.
    bus.rsp0Ready = 1'b0;
    sendReq(0, 4'b0001, 32'h1234_0000, 32'h0000_5678);
    n = 0;
    while (!bus.rsp0Valid && n < 20) begin
      @(negedge clock);
      n++;
    end
    check("t5RspUp", 64'(bus.rsp0Valid), 64'd1);
    driveReq(1, 4'b0010, 32'd1, 32'd2);
    repeat (5) begin
      @(negedge clock);
      check("t5Hold", 64'({bus.rsp0Valid, bus.req1Ready}), 64'd2);
      check("t5Result", 64'(bus.rsp0Result), 64'h1234_5678);
    end
    @(posedge clock);
    #1;
    bus.rsp0Ready = 1'b1;
    waitAccept(1);
    waitIdle();

    // Randomized traffic with random response backpressure.
    randDone = 1'b0;
    fork
      begin
        fork
          randPort(0, 30);
          randPort(1, 30);
        join
        randDone = 1'b1;
      end
      begin
        while (!randDone) begin
          @(posedge clock);
          #1;
          bus.rsp0Ready = 1'($urandom_range(0, 1));
          bus.rsp1Ready = 1'($urandom_range(0, 1));
        end
      end
    join
    bus.rsp0Ready = 1'b1;
    bus.rsp1Ready = 1'b1;
    waitIdle();

    // Reset asserted during EXEC drops the transaction.
    sendReq(0, 4'b0010, 32'd3, 32'd4);
    bus.req1Valid = 1'b1;
    #2;
    resetN = 1'b0;
    #1;
    check("t6Handshake", 64'({bus.req0Ready, bus.req1Ready, bus.rsp0Valid, bus.rsp1Valid}), 64'd0);
    check("t6Rsp", 64'({bus.rsp0Result, bus.rsp0Zero, bus.rsp0Err}), 64'd0);
    check("t6Alu", 64'({bus.aluControl, bus.aluInput1}), 64'd0);
    repeat (2) @(negedge clock);
    bus.req1Valid = 1'b0;
    resetN = 1'b1;
    repeat (5) begin
      @(negedge clock);
      check("t6NoRsp", 64'({bus.rsp0Valid, bus.rsp1Valid}), 64'd0);
    end
    @(posedge clock);
    #1;
    sendReq(0, 4'b0110, 32'd10, 32'd3);
    waitIdle();
    check("t6Served", 64'(grantLog.size()), 64'd1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
